conv_layer_seq: RTL and testbench

CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_acc_bank.sv | 48 ++++
 rtl/conv_layer_seq.sv | 129 ++++++++++++
 tb/tb_conv_layer_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, default widths and saturation limits for conv_layer_seq
package conv_pkg;

    localparam int CELLS_DEF = 11;
    localparam int ACC_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ACC,
        ST_OUT
    } conv_state_e;

    // Limits are returned 64 bits wide; callers truncate to their own ACC_W (<= 64).
    function automatic logic [63:0] sat_max_of(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_of(input int w);
        return ~sat_max_of(w);
    endfunction

endpackage

// File: rtl/conv_acc_bank.sv
// rtl/conv_acc_bank.sv - CELLS signed accumulators with load, add and optional saturation
module conv_acc_bank
    import conv_pkg::*;
#(
    parameter int CELLS = CELLS_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   en,
    input  logic                   load,
    input  logic                   sat_en,
    input  logic [CELLS*ACC_W-1:0] dp_out,
    output logic [CELLS*ACC_W-1:0] acc_data
);

    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max_of(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min_of(ACC_W));

    for (genvar i = 0; i < CELLS; i++) begin : g_lane
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] addend;
        logic [ACC_W:0]   sum_ext;
        logic [ACC_W-1:0] sum_next;

        // Lane 0 lives in the most significant slice.
        assign addend  = dp_out[(CELLS-1-i)*ACC_W +: ACC_W];
        assign sum_ext = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};

        always_comb begin
            sum_next = sum_ext[ACC_W-1:0];
            if (sat_en && (sum_ext[ACC_W] != sum_ext[ACC_W-1])) begin
                sum_next = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                acc_q <= '0;
            end else if (en) begin
                acc_q <= load ? addend : sum_next;
            end
        end

        assign acc_data[(CELLS-1-i)*ACC_W +: ACC_W] = acc_q;
    end

endmodule

// File: rtl/conv_layer_seq.sv
// rtl/conv_layer_seq.sv - layer fetch/accumulate sequencer; CONV_LAYER_SEQ_SAT_EN enables saturation
module conv_layer_seq
    import conv_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int CELLS      = CELLS_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int DP_LAT     = 1
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   layer_req,
    output logic [5:0]             layer_idx,
    input  logic                   layer_vld,
    output logic                   dp_en,
    input  logic [CELLS*ACC_W-1:0] dp_out,
    output logic [CELLS*ACC_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done
);

`ifdef CONV_LAYER_SEQ_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam logic [5:0] LAST_IDX = 6'(NUM_LAYERS - 1);
    localparam logic [2:0] LAT_LAST = 3'(DP_LAT - 1);

    conv_state_e state, state_nxt;
    logic [5:0]  idx_nxt;
    logic [2:0]  lat_cnt, cnt_nxt;
    logic        acc_en, acc_load;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_IDLE;
            layer_idx <= '0;
            lat_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            layer_idx <= idx_nxt;
            lat_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = layer_idx;
        cnt_nxt   = '0;
        busy      = (state != ST_IDLE);
        layer_req = 1'b0;
        dp_en     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        acc_en    = 1'b0;
        acc_load  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    idx_nxt   = '0;
                end
            end
            ST_FETCH: begin
                layer_req = 1'b1;
                if (layer_vld) begin
                    dp_en     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = ST_ACC;
                end else begin
                    cnt_nxt = lat_cnt + 3'd1;
                end
            end
            ST_ACC: begin
                acc_en   = 1'b1;
                acc_load = (layer_idx == 6'd0);
                if (layer_idx == LAST_IDX) begin
                    state_nxt = ST_OUT;
                end else begin
                    state_nxt = ST_FETCH;
                    idx_nxt   = layer_idx + 6'd1;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort wins over every other event, including a same-cycle out_ready.
        if (abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = layer_idx;
            cnt_nxt   = '0;
            dp_en     = 1'b0;
            acc_en    = 1'b0;
            done      = 1'b0;
        end
    end

    conv_acc_bank #(
        .CELLS (CELLS),
        .ACC_W (ACC_W)
    ) u_acc_bank (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (acc_en),
        .load     (acc_load),
        .sat_en   (SAT_EN),
        .dp_out   (dp_out),
        .acc_data (out_data)
    );

endmodule

// File: tb/tb_conv_layer_seq.sv
// tb/tb_conv_layer_seq.sv - scoreboard bench for conv_layer_seq
module tb_conv_layer_seq;

    localparam int NL     = 4;
    localparam int CELLS  = 11;
    localparam int ACC_W  = 32;
    localparam int DP_LAT = 1;
    localparam int DW     = CELLS * ACC_W;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          layer_vld = 1'b1;
    logic          out_ready = 1'b0;
    logic          busy, layer_req, dp_en, out_valid, done;
    logic [5:0]    layer_idx;
    logic [DW-1:0] dp_out, out_data;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   lay_tab[4];
    logic [31:0]   step = '0;

    always #5 clk = ~clk;

    conv_layer_seq #(
        .NUM_LAYERS (NL),
        .CELLS      (CELLS),
        .ACC_W      (ACC_W),
        .DP_LAT     (DP_LAT)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .layer_req (layer_req),
        .layer_idx (layer_idx),
        .layer_vld (layer_vld),
        .dp_en     (dp_en),
        .dp_out    (dp_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    // Datapath stand-in: lane value depends on the layer being accumulated.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            dp_out[(CELLS-1-i)*ACC_W +: ACC_W] = lay_tab[layer_idx[1:0]] + step * 32'(i);
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] lanes(input logic [31:0] base, input logic [31:0] inc);
        logic [DW-1:0] r;
        for (int i = 0; i < CELLS; i++) begin
            r[(CELLS-1-i)*ACC_W +: ACC_W] = base + inc * 32'(i);
        end
        return r;
    endfunction

    task automatic set_layers(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d, input logic [31:0] s);
        lay_tab[0] = a;
        lay_tab[1] = b;
        lay_tab[2] = c;
        lay_tab[3] = d;
        step       = s;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    // Monitor: sampled mid-low-phase, after inputs change and before the acting edge.
    always @(negedge clk) begin
        #2;
        if (rst_b) begin
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    check("done_on_accept", done, 1);
                end
            end else if (done) begin
                check("spurious_done", done, 0);
            end
        end
    end

    initial begin
        int cyc;
        int k;
        set_layers(32'd5, 32'd5, 32'd5, 32'd5, 32'd0);

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_layer_req", layer_req, 0);
        check("rst_dp_en", dp_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_layer_idx", layer_idx, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        // Four layers of 5, layer_vld tied high: valid at cycle 13, lanes = 20
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 60);
        check("first_valid_cycle", cyc, 13);
        exp_q.push_back(lanes(32'd20, 32'd0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_accept", busy, 0);

        // layer_vld stalls FETCH for 3 cycles; signed layers 1,-2,3,-4 sum to -2
        set_layers(32'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFC, 32'd0);
        layer_vld = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("stall_dp_en", dp_en, 0);
            check("stall_layer_req", layer_req, 1);
            check("stall_layer_idx", layer_idx, 0);
            @(negedge clk);
        end
        layer_vld = 1'b1;
        exp_q.push_back(lanes(32'hFFFF_FFFE, 32'd0));
        out_ready = 1'b1;
        wait_idle(100);
        out_ready = 1'b0;

        // Backpressure for 5 cycles with a start pulse ignored in OUT; lanes 20+4i
        set_layers(32'd5, 32'd5, 32'd5, 32'd5, 32'd1);
        pulse_start();
        wait_valid(60);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, lanes(32'd20, 32'd4));
            check("hold_done", done, 0);
            start = (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        check("start_ignored_req", layer_req, 0);
        check("start_ignored_valid", out_valid, 1);
        check("start_ignored_idx", layer_idx, 3);
        exp_q.push_back(lanes(32'd20, 32'd4));
        out_ready = 1'b1;
        wait_idle(20);
        out_ready = 1'b0;

        // Abort at layer 2, then a clean run of ones gives 4
        set_layers(32'd7, 32'd7, 32'd7, 32'd7, 32'd0);
        pulse_start();
        k = 0;
        while (layer_idx != 6'd2 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("reached_layer2", layer_idx, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_layer_req", layer_req, 0);
        check("abort_out_valid", out_valid, 0);
        set_layers(32'd1, 32'd1, 32'd1, 32'd1, 32'd0);
        exp_q.push_back(lanes(32'd4, 32'd0));
        out_ready = 1'b1;
        pulse_start();
        wait_idle(100);
        out_ready = 1'b0;

        // Abort beats out_ready in the same cycle
        set_layers(32'd3, 32'd3, 32'd3, 32'd3, 32'd0);
        pulse_start();
        wait_valid(60);
        abort = 1'b1;
        out_ready = 1'b1;
        #1;
        check("abort_beats_ready_done", done, 0);
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_in_out_valid", out_valid, 0);
        check("abort_in_out_busy", busy, 0);

        // Overflow: two layers of 0x7FFFFFF0 then zeros
        set_layers(32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'd0, 32'd0, 32'd0);
`ifdef CONV_LAYER_SEQ_SAT_EN
        exp_q.push_back(lanes(32'h7FFF_FFFF, 32'd0));
`else
        exp_q.push_back(lanes(32'hFFFF_FFE0, 32'd0));
`endif
        out_ready = 1'b1;
        pulse_start();
        wait_idle(100);
        out_ready = 1'b0;

        // Reset while in WAIT
        set_layers(32'd9, 32'd9, 32'd9, 32'd9, 32'd0);
        pulse_start();
        k = 0;
        while (!dp_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("saw_dp_en", dp_en, 1);
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_layer_req", layer_req, 0);
        check("midrst_dp_en", dp_en, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_layer_idx", layer_idx, 0);
        check("midrst_out_data", out_data, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("postrst_busy", busy, 0);

        // Fresh run after reset: layers of 2 give 8
        set_layers(32'd2, 32'd2, 32'd2, 32'd2, 32'd0);
        exp_q.push_back(lanes(32'd8, 32'd0));
        out_ready = 1'b1;
        pulse_start();
        wait_idle(100);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
